if_id_skid: RTL

- Parametrised IF→ID pipeline stage that replaces the plain per-clock register with a valid/ready handshake and a 2-entry skid buffer.
- It accepts fetched instructions from IF at full throughput and holds them while ID stalls.
- It supports a flush from branch/jump resolution that squashes everything in flight.
- It sits between the fetch unit and the decoder; if_ready is registered so the backpressure path does not reach combinationally into fetch.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/skid_buf.sv | 140 ++++++++++++++
 rtl/if_id_skid.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the in-order pipeline stage registers.
//   - skid_state_e : occupancy state of a 2-entry valid/ready skid buffer
//   - DEF_ADDR_W / DEF_INST_W : default address / instruction widths
//   - DEF_NOP_INST : instruction word shown to decode when nothing is valid
//   - if_id_t      : IF->ID payload at the default widths (pc, inst)
//   - state_occ()  : entry count held in a given skid state
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  localparam logic [DEF_INST_W-1:0] DEF_NOP_INST = {DEF_INST_W{1'b0}};

  // Payload layout at the default widths; wider/narrower instances of
  // if_id_skid declare the same {pc, inst} layout with their own widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } if_id_t;

  // Number of entries held in each state.
  function automatic logic [1:0] state_occ(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// -----------------------------------------------------------------------------
// skid_buf
//   Generic 2-entry valid/ready skid buffer on a packed payload type T.
//   MAIN drives the output; SKID catches the one entry that arrives while the
//   consumer stalls after o_ready was already high. o_ready is registered so
//   the consumer's i_ready never reaches the producer combinationally.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   i_flush      synchronous squash of all held entries (wins over input)
//   i_valid      producer offers i_data
//   o_ready      buffer can accept an entry this cycle (registered)
//   i_data       producer payload
//   o_valid      o_data holds a valid entry (registered)
//   i_ready      consumer takes o_data this cycle
//   o_data       head-of-queue payload (MAIN); undefined when !o_valid
//   o_occupancy  entries held, 0..2 (registered)
// -----------------------------------------------------------------------------
module skid_buf
  import pipe_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_valid,
  output logic       o_ready,
  input  T           i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output T           o_data,
  output logic [1:0] o_occupancy
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  logic        r_ready;
  logic        r_valid;
  logic [1:0]  r_occ;
  T            r_main;
  T            r_skid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  assign w_in_xfer  = i_valid & r_ready;
  assign w_out_xfer = r_valid & i_ready;

  // Next-state and data-steering decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      // Everything in flight is discarded, including an entry offered on
      // this very edge; a concurrent output transfer was still consumed.
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = BUSY;
            w_load_main = 1'b1;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_state_nxt = BUSY;
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = FULL;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = BUSY;
          end
        end
        FULL: begin
          // o_ready is low here, so no input transfer can coincide.
          if (w_out_xfer) begin
            w_state_nxt      = BUSY;
            w_main_from_skid = 1'b1;
          end else begin
            w_state_nxt = FULL;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Control registers: state plus the registered handshake/status outputs,
  // all derived from the next state so they are valid right after each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != FULL);
      r_valid <= (w_state_nxt != EMPTY);
      r_occ   <= state_occ(w_state_nxt);
    end
  end

  // Payload registers; never observed while invalid, so left without reset.
  always_ff @(posedge clk) begin
    if (w_load_main) begin
      r_main <= i_data;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end else begin
      r_main <= r_main;
    end
    if (w_load_skid) begin
      r_skid <= i_data;
    end else begin
      r_skid <= r_skid;
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_main;
  assign o_occupancy = r_occ;

endmodule

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
//   IF->ID pipeline stage with valid/ready handshake and a 2-entry skid
//   buffer. Fetch runs at full rate while decode accepts; when decode stalls
//   the stage absorbs one extra entry before dropping if_ready. A flush from
//   branch/jump resolution squashes everything held. When nothing is valid
//   the decoder sees pc 0 and NOP_INST.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   flush      squash all buffered entries
//   if_valid   IF presents if_pc/if_inst
//   if_ready   stage can accept this cycle (registered)
//   if_pc      fetched address
//   if_inst    fetched instruction
//   id_valid   id_pc/id_inst hold a valid entry
//   id_ready   ID consumes the entry this cycle
//   id_pc      address to decode (0 when !id_valid)
//   id_inst    instruction to decode (NOP_INST when !id_valid)
//   occupancy  entries held, 0..2
// -----------------------------------------------------------------------------
module if_id_skid
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occupancy
);

  // Same {pc, inst} layout as pipe_pkg::if_id_t, sized by this instance.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } payload_t;

  payload_t   w_in;
  payload_t   w_out;
  logic       w_valid;
  logic       w_ready;
  logic [1:0] w_occ;

  assign w_in.pc   = if_pc;
  assign w_in.inst = if_inst;

  skid_buf #(
    .T (payload_t)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_valid     (if_valid),
    .o_ready     (w_ready),
    .i_data      (w_in),
    .o_valid     (w_valid),
    .i_ready     (id_ready),
    .o_data      (w_out),
    .o_occupancy (w_occ)
  );

  // Bubble substitution: decode sees a clean NOP at pc 0 while invalid.
  // Both sides of the mux come straight from registers.
  always_comb begin
    if (w_valid) begin
      id_pc   = w_out.pc;
      id_inst = w_out.inst;
    end else begin
      id_pc   = {ADDR_W{1'b0}};
      id_inst = NOP_INST;
    end
  end

  assign if_ready  = w_ready;
  assign id_valid  = w_valid;
  assign occupancy = w_occ;

endmodule
